// File: rtl/seq_signed_divider_module.sv
// Sequential 16/8 signed divider: restoring unsigned core on magnitudes, signs fixed up at the end.
// Optional divide-by-zero shortcut (ZERO state, div_zero flag) enabled by macro DIV_ZERO_CHK_EN.
module seq_signed_divider_module (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

`ifdef DIV_ZERO_CHK_EN
   typedef enum logic [1:0] {IDLE, CALC, SIGN, ZERO} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
`endif

   state_t      state, state_nxt;
   logic [3:0]  count, count_nxt;
   logic [15:0] q_acc, q_acc_nxt;
   logic [7:0]  r_acc, r_acc_nxt;
   logic [7:0]  dsr_mag, dsr_mag_nxt;
   logic        q_neg, q_neg_nxt;
   logic        r_neg, r_neg_nxt;
   logic [15:0] quotient_nxt;
   logic [7:0]  remainder_nxt;
   logic        busy_nxt, done_nxt;
   logic [8:0]  partial;
   logic [7:0]  diff;
   logic        fits;

   // Partial remainder is always below the divisor magnitude, so an 8-bit wrapped difference is exact.
   always_comb begin
      partial = {r_acc, q_acc[15]};
      fits    = (partial >= {1'b0, dsr_mag});
      diff    = partial[7:0] - dsr_mag;
   end

`ifdef DIV_ZERO_CHK_EN
   logic dz_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      q_acc_nxt     = q_acc;
      r_acc_nxt     = r_acc;
      dsr_mag_nxt   = dsr_mag;
      q_neg_nxt     = q_neg;
      r_neg_nxt     = r_neg;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
`ifdef DIV_ZERO_CHK_EN
      dz_nxt        = div_zero;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               q_acc_nxt   = dividend[15] ? (~dividend + 16'd1) : dividend;
               dsr_mag_nxt = divisor[7] ? (~divisor + 8'd1) : divisor;
               r_acc_nxt   = '0;
               q_neg_nxt   = dividend[15] ^ divisor[7];
               r_neg_nxt   = dividend[15];
               count_nxt   = '0;
               busy_nxt    = 1'b1;
`ifdef DIV_ZERO_CHK_EN
               state_nxt   = (divisor == '0) ? ZERO : CALC;
`else
               state_nxt   = CALC;
`endif
            end
         end
         CALC: begin
            q_acc_nxt = {q_acc[14:0], fits};
            r_acc_nxt = fits ? diff : partial[7:0];
            count_nxt = count + 4'd1;
            if (count == 4'd15) state_nxt = SIGN;
         end
         SIGN: begin
            quotient_nxt  = q_neg ? (~q_acc + 16'd1) : q_acc;
            remainder_nxt = r_neg ? (~r_acc + 8'd1) : r_acc;
            done_nxt      = 1'b1;
            busy_nxt      = 1'b0;
`ifdef DIV_ZERO_CHK_EN
            dz_nxt        = 1'b0;
`endif
            state_nxt     = IDLE;
         end
`ifdef DIV_ZERO_CHK_EN
         ZERO: begin
            quotient_nxt  = r_neg ? 16'h8000 : 16'h7FFF;
            remainder_nxt = '0;
            dz_nxt        = 1'b1;
            done_nxt      = 1'b1;
            busy_nxt      = 1'b0;
            state_nxt     = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         q_acc     <= '0;
         r_acc     <= '0;
         dsr_mag   <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         q_acc     <= q_acc_nxt;
         r_acc     <= r_acc_nxt;
         dsr_mag   <= dsr_mag_nxt;
         q_neg     <= q_neg_nxt;
         r_neg     <= r_neg_nxt;
         quotient  <= quotient_nxt;
         remainder <= remainder_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

`ifdef DIV_ZERO_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_zero <= 1'b0;
      else        div_zero <= dz_nxt;
   end
`else
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_divider_module.sv
// Self-checking bench for seq_signed_divider_module: arithmetic reference model plus directed vectors.
// Define DIV_ZERO_CHK_EN for both bench and RTL to exercise the divide-by-zero path.
module tb_seq_signed_divider_module;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   int          inj_at = -1;
   logic [15:0] inj_a = '0;
   logic [7:0]  inj_b = '0;
   bit          chain_en = 0;
   logic [15:0] chain_a = '0;
   logic [7:0]  chain_b = '0;

   seq_signed_divider_module dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a division accepted when idle finishes 17 edges later with plain signed / and %.
   logic        m_busy = 0, m_done = 0, m_dz = 0;
   logic [15:0] m_q = '0, m_a = '0;
   logic [7:0]  m_r = '0, m_b = '0;
   int          m_left = 0;
   int          sa, sb, qi, ri;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0;
               m_done = 1;
               if (m_b == 8'd0) begin
                  m_q  = m_a[15] ? 16'h8000 : 16'h7FFF;
                  m_r  = '0;
                  m_dz = 1;
               end else begin
                  sa = int'($signed(m_a));
                  sb = int'($signed(m_b));
                  qi = sa / sb;
                  ri = sa % sb;
                  m_q  = qi[15:0];
                  m_r  = ri[7:0];
                  m_dz = 0;
               end
            end
         end else if (start) begin
            m_busy = 1;
            m_a    = dividend;
            m_b    = divisor;
            m_left = 17;
`ifdef DIV_ZERO_CHK_EN
            if (divisor == 8'd0) m_left = 1;
`endif
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("quotient", 32'(quotient), 32'(m_q));
         chk("remainder", 32'(remainder), 32'(m_r));
         chk("div_zero", 32'(div_zero), 32'(m_dz));
      end
   end

   task automatic run_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input int exp_lat, input bit pre);
      int lat, bcnt;
      bit seen;
      if (!pre) begin
         @(negedge clk);
         dividend = a; divisor = b; start = 1'b1;
      end
      @(posedge clk);
      lat = 0; bcnt = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (lat == inj_at - 1) begin
            dividend = inj_a; divisor = inj_b; start = 1'b1;
         end
         if (busy) bcnt++;
         if (done) begin
            seen = 1;
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("busy_cycles", 32'(bcnt), 32'(exp_lat));
            chk("lit_quotient", 32'(quotient), 32'(eq));
            chk("lit_remainder", 32'(remainder), 32'(er));
            if (chain_en) begin
               dividend = chain_a; divisor = chain_b; start = 1'b1;
            end
         end else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!seen) chk("done_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst_quotient", 32'(quotient), 32'(0));
      chk("rst_remainder", 32'(remainder), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_div_zero", 32'(div_zero), 32'(0));
      chk_en = 1;
      @(negedge clk);
      rst_n = 1'b1;

      run_div(16'd100,   8'd7,   16'd14,   8'd2,  17, 1'b0);
      run_div(16'hFF9C,  8'd7,   16'hFFF2, 8'hFE, 17, 1'b0);
      run_div(16'd12345, 8'h80,  16'hFFA0, 8'd57, 17, 1'b0);
      run_div(16'h8000,  8'hFF,  16'h8000, 8'h00, 17, 1'b0);
      run_div(16'h7FFF,  8'h7F,  16'h0102, 8'h01, 17, 1'b0);
      run_div(16'h8000,  8'h7F,  16'hFEFE, 8'hFE, 17, 1'b0);
      run_div(16'h7FFF,  8'h80,  16'hFF01, 8'h7F, 17, 1'b0);

      // Start during busy is ignored; start on the done cycle is accepted.
      inj_at = 5; inj_a = 16'd7; inj_b = 8'd1;
      chain_en = 1; chain_a = 16'hFFF9; chain_b = 8'd2;
      run_div(16'd1000, 8'd9, 16'd111, 8'd1, 17, 1'b0);
      inj_at = -1; chain_en = 0;
      run_div(16'hFFF9, 8'd2, 16'hFFFD, 8'hFF, 17, 1'b1);

      // Reset mid-operation aborts the division.
      @(negedge clk);
      dividend = 16'd1000; divisor = 8'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_quotient", 32'(quotient), 32'(0));
      chk("abort_remainder", 32'(remainder), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_div_zero", 32'(div_zero), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1; dividend = 16'd50; divisor = 8'd5; start = 1'b1;
      run_div(16'd50, 8'd5, 16'd10, 8'd0, 17, 1'b1);

`ifdef DIV_ZERO_CHK_EN
      run_div(16'hFFFB, 8'd0, 16'h8000, 8'h00, 1, 1'b0);
      chk("lit_div_zero_set", 32'(div_zero), 32'(1));
      run_div(16'd9, 8'd3, 16'd3, 8'd0, 17, 1'b0);
      chk("lit_div_zero_clr", 32'(div_zero), 32'(0));
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=%0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
